// File: rtl/fu_mem_pkg.sv
// Shared encodings and lane helpers for the pipelined memory functional unit.
package fu_mem_pkg;

   localparam logic [2:0] BHW_B  = 3'b000;
   localparam logic [2:0] BHW_H  = 3'b001;
   localparam logic [2:0] BHW_W  = 3'b010;
   localparam logic [2:0] BHW_BU = 3'b100;
   localparam logic [2:0] BHW_HU = 3'b101;

   localparam int WORD_W = 32;
   localparam int LANES  = WORD_W / 8;
   localparam int MIS_W  = 1;

   function automatic int resp_w(input int tag_w, input int xlen);
      return tag_w + xlen + MIS_W;
   endfunction

   // Unsupported size codes behave as a full word access.
   function automatic logic [2:0] bhw_norm(input logic [2:0] bhw);
      case (bhw)
         BHW_B, BHW_H, BHW_W, BHW_BU, BHW_HU: return bhw;
         default:                            return BHW_W;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [2:0] bhw, input logic [1:0] lane);
      case (bhw[1:0])
         2'b01:   return lane[0];
         2'b10:   return lane != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [LANES-1:0] byte_en(input logic [2:0] bhw, input logic [1:0] lane);
      case (bhw[1:0])
         2'b00:   return 4'b0001 << lane;
         2'b01:   return 4'b0011 << lane;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [WORD_W-1:0] lane_shift(input logic [WORD_W-1:0] data, input logic [1:0] lane);
      return data << {lane, 3'b000};
   endfunction

   function automatic logic [WORD_W-1:0] load_extract(input logic [WORD_W-1:0] word,
                                                      input logic [2:0] bhw,
                                                      input logic [1:0] lane);
      logic [WORD_W-1:0] sh;
      sh = word >> {lane, 3'b000};
      case (bhw)
         BHW_B:   return {{24{sh[7]}}, sh[7:0]};
         BHW_BU:  return {24'h0, sh[7:0]};
         BHW_H:   return {{16{sh[15]}}, sh[15:0]};
         BHW_HU:  return {16'h0, sh[15:0]};
         default: return word;
      endcase
   endfunction

endpackage

// File: rtl/mem_resp_fifo.sv
// Response FIFO with registered head; push is visible at the head the cycle after the edge.
// No full check: the producer's credit scheme guarantees space for every push.
module mem_resp_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [W-1:0]               push_dat,
   input  logic                       pop,
   output logic                       head_vld,
   output logic [W-1:0]               head_dat,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr, rd_nxt;
   logic [CW-1:0] cnt_nxt, remain;
   logic          do_pop;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign do_pop  = pop & head_vld;
   assign rd_nxt  = do_pop ? inc(rd_ptr) : rd_ptr;
   assign remain  = count - CW'(do_pop);
   assign cnt_nxt = remain + CW'(push);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_dat;
   end

   // Head is reloaded from storage, or from the push itself when nothing else remains.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         head_vld <= 1'b0;
         head_dat <= '0;
      end else begin
         if (push) wr_ptr <= inc(wr_ptr);
         rd_ptr   <= rd_nxt;
         count    <= cnt_nxt;
         head_vld <= cnt_nxt != '0;
         if (remain == '0) head_dat <= push ? push_dat : '0;
         else              head_dat <= mem[rd_nxt];
      end
   end
endmodule

// File: rtl/fu_mem_pipe.sv
// Pipelined load/store unit: one op/cycle, in-order tagged responses after 2+EXTRA_LAT edges.
// in_ready drops when in-flight plus queued responses reach RESP_DEPTH; the pipe never stalls.
module fu_mem_pipe
   import fu_mem_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int ADDR_W     = 10,
   parameter int TAG_W      = 4,
   parameter int EXTRA_LAT  = 0,
   parameter int RESP_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_mem_w,
   input  logic [2:0]       in_bhw,
   input  logic [XLEN-1:0]  in_rs1,
   input  logic [XLEN-1:0]  in_rs2,
   input  logic [XLEN-1:0]  in_imm,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [TAG_W-1:0] out_tag,
   output logic [XLEN-1:0]  out_data,
   output logic             out_misalign,
   output logic             busy
);
   localparam int CW = $clog2(RESP_DEPTH + 1);

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [XLEN-1:0]  data;
      logic             mis;
   } resp_t;

   logic          acc, deq, enq_vld;
   logic [CW-1:0] inflight, fifo_cnt, credits;
   resp_t         res_dat, enq_dat, head;

   assign credits  = inflight + fifo_cnt;
   assign in_ready = credits < CW'(RESP_DEPTH);
   assign busy     = credits != '0;
   assign acc      = in_valid & in_ready;
   assign deq      = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (rst) inflight <= '0;
      else     inflight <= inflight + CW'(acc) - CW'(enq_vld);
   end

   // Stage A: address generation and access classification
   logic [XLEN-1:0]   addr_nxt;
   logic [2:0]        bhw_nxt;
   logic              a_vld, a_mem_w, a_mis;
   logic [2:0]        a_bhw;
   logic [1:0]        a_lane;
   logic [ADDR_W-1:0] a_idx;
   logic [WORD_W-1:0] a_wdat;
   logic [TAG_W-1:0]  a_tag;
   logic              unused_addr;

   assign addr_nxt    = in_rs1 + in_imm;
   assign bhw_nxt     = bhw_norm(in_bhw);
   assign unused_addr = ^addr_nxt[XLEN-1:ADDR_W+2];

   always_ff @(posedge clk) begin
      if (rst) begin
         a_vld <= 1'b0;
      end else begin
         a_vld <= acc;
         if (acc) begin
            a_mem_w <= in_mem_w;
            a_bhw   <= bhw_nxt;
            a_lane  <= addr_nxt[1:0];
            a_idx   <= addr_nxt[ADDR_W+1:2];
            a_wdat  <= lane_shift(in_rs2[WORD_W-1:0], addr_nxt[1:0]);
            a_tag   <= in_tag;
            a_mis   <= is_misaligned(bhw_nxt, addr_nxt[1:0]);
         end
      end
   end

   // RAM stage: a store is dropped if reset lands on its write edge
   logic [WORD_W-1:0] ram [2**ADDR_W];
   logic [WORD_W-1:0] ram_q;
   logic [LANES-1:0]  a_be;

   assign a_be = byte_en(a_bhw, a_lane);

   always_ff @(posedge clk) begin
      if (!rst && a_vld && a_mem_w && !a_mis) begin
         for (int i = 0; i < LANES; i++) begin
            if (a_be[i]) ram[a_idx][8*i +: 8] <= a_wdat[8*i +: 8];
         end
      end
      ram_q <= ram[a_idx];
   end

   logic             b_vld, b_mem_w, b_mis;
   logic [2:0]       b_bhw;
   logic [1:0]       b_lane;
   logic [TAG_W-1:0] b_tag;

   always_ff @(posedge clk) begin
      if (rst) begin
         b_vld <= 1'b0;
      end else begin
         b_vld   <= a_vld;
         b_mem_w <= a_mem_w;
         b_mis   <= a_mis;
         b_bhw   <= a_bhw;
         b_lane  <= a_lane;
         b_tag   <= a_tag;
      end
   end

   always_comb begin
      res_dat      = '0;
      res_dat.tag  = b_tag;
      res_dat.mis  = b_mis;
      if (!b_mem_w && !b_mis)
         res_dat.data = XLEN'($signed(load_extract(ram_q, b_bhw, b_lane)));
   end

   generate
      if (EXTRA_LAT == 0) begin : g_nodly
         assign enq_vld = b_vld;
         assign enq_dat = res_dat;
      end else begin : g_dly
         logic [EXTRA_LAT-1:0] dly_vld;
         resp_t                dly_dat [EXTRA_LAT];

         always_ff @(posedge clk) begin
            if (rst) dly_vld <= '0;
            else begin
               dly_vld[0] <= b_vld;
               for (int k = 1; k < EXTRA_LAT; k++) dly_vld[k] <= dly_vld[k-1];
            end
            dly_dat[0] <= res_dat;
            for (int k = 1; k < EXTRA_LAT; k++) dly_dat[k] <= dly_dat[k-1];
         end

         assign enq_vld = dly_vld[EXTRA_LAT-1];
         assign enq_dat = dly_dat[EXTRA_LAT-1];
      end
   endgenerate

   mem_resp_fifo #(
      .W     ($bits(resp_t)),
      .DEPTH (RESP_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (enq_vld),
      .push_dat (enq_dat),
      .pop      (deq),
      .head_vld (out_valid),
      .head_dat (head),
      .count    (fifo_cnt)
   );

   assign out_tag      = head.tag;
   assign out_data     = head.data;
   assign out_misalign = head.mis;
endmodule

// File: tb/tb_fu_mem_pipe.sv
// Directed bench for fu_mem_pipe: vector table plus handshake/latency/reset sequences.
module tb_fu_mem_pipe;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid, in_ready, in_mem_w, out_valid, out_ready, out_misalign, busy;
   logic [2:0]  in_bhw;
   logic [31:0] in_rs1, in_rs2, in_imm, out_data;
   logic [3:0]  in_tag, out_tag;

   logic        l_in_valid, l_in_ready, l_in_mem_w, l_out_valid, l_out_ready, l_out_misalign, l_busy;
   logic [2:0]  l_in_bhw;
   logic [31:0] l_in_rs1, l_in_rs2, l_in_imm, l_out_data;
   logic [3:0]  l_in_tag, l_out_tag;

   fu_mem_pipe #(.EXTRA_LAT(0), .RESP_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mem_w(in_mem_w),
      .in_bhw(in_bhw), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_data(out_data),
      .out_misalign(out_misalign), .busy(busy));

   fu_mem_pipe #(.EXTRA_LAT(3), .RESP_DEPTH(4)) dut_l3 (
      .clk(clk), .rst(rst), .in_valid(l_in_valid), .in_ready(l_in_ready), .in_mem_w(l_in_mem_w),
      .in_bhw(l_in_bhw), .in_rs1(l_in_rs1), .in_rs2(l_in_rs2), .in_imm(l_in_imm), .in_tag(l_in_tag),
      .out_valid(l_out_valid), .out_ready(l_out_ready), .out_tag(l_out_tag), .out_data(l_out_data),
      .out_misalign(l_out_misalign), .busy(l_busy));

   typedef struct {
      logic        mem_w;
      logic [2:0]  bhw;
      logic [31:0] rs1, imm, rs2;
      logic [3:0]  tag;
      logic [31:0] exp_data;
      logic        exp_mis;
   } vec_t;

   localparam int NV = 21;
   vec_t tbl [NV];
   int   n_pass = 0, n_total = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic timeout(input string nm);
      n_total++;
      $display("FAIL %s: no response within cycle budget", nm);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic w, input logic [2:0] b, input logic [31:0] rs1,
                        input logic [31:0] imm, input logic [31:0] rs2, input logic [3:0] tag);
      in_valid = 1'b1; in_mem_w = w; in_bhw = b;
      in_rs1 = rs1; in_imm = imm; in_rs2 = rs2; in_tag = tag;
   endtask

   // Isolated op: accept, then expect the response exactly two edges later.
   task automatic do_op(input vec_t v, input string nm);
      int lat;
      drive(v.mem_w, v.bhw, v.rs1, v.imm, v.rs2, v.tag);
      lat = 0;
      while (!in_ready && lat < 20) begin tick; lat++; end
      tick;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin tick; lat++; end
      if (!out_valid) timeout(nm);
      else begin
         chk({nm, ".lat"}, lat, 2);
         chk({nm, ".tag"}, {28'h0, out_tag}, {28'h0, v.tag});
         chk({nm, ".data"}, out_data, v.exp_data);
         chk({nm, ".mis"}, {31'h0, out_misalign}, {31'h0, v.exp_mis});
      end
      tick;
   endtask

   initial begin
      int n_acc, lat;
      logic acc_now;

      //          w     bhw     rs1          imm          rs2          tag    exp_data     mis
      tbl[0]  = '{1'b1, 3'b010, 32'h10,      32'h0,       32'hDEADBEEF, 4'd1,  32'h0,        1'b0};
      tbl[1]  = '{1'b0, 3'b010, 32'h10,      32'h0,       32'h0,        4'd2,  32'hDEADBEEF, 1'b0};
      tbl[2]  = '{1'b1, 3'b010, 32'h10,      32'h0,       32'h11223344, 4'd3,  32'h0,        1'b0};
      tbl[3]  = '{1'b1, 3'b000, 32'h10,      32'h3,       32'h80,       4'd4,  32'h0,        1'b0};
      tbl[4]  = '{1'b0, 3'b000, 32'h13,      32'h0,       32'h0,        4'd5,  32'hFFFFFF80, 1'b0};
      tbl[5]  = '{1'b0, 3'b100, 32'h13,      32'h0,       32'h0,        4'd6,  32'h00000080, 1'b0};
      tbl[6]  = '{1'b0, 3'b001, 32'h12,      32'h0,       32'h0,        4'd7,  32'hFFFF8022, 1'b0};
      tbl[7]  = '{1'b0, 3'b101, 32'h12,      32'h0,       32'h0,        4'd8,  32'h00008022, 1'b0};
      tbl[8]  = '{1'b0, 3'b010, 32'h10,      32'h0,       32'h0,        4'd9,  32'h80223344, 1'b0};
      tbl[9]  = '{1'b1, 3'b010, 32'h100,     32'h0,       32'hCAFEF00D, 4'd10, 32'h0,        1'b0};
      tbl[10] = '{1'b0, 3'b010, 32'h101,     32'h0,       32'h0,        4'd11, 32'h0,        1'b1};
      tbl[11] = '{1'b1, 3'b001, 32'h103,     32'h0,       32'h0000FFFF, 4'd12, 32'h0,        1'b1};
      tbl[12] = '{1'b0, 3'b010, 32'h100,     32'h0,       32'h0,        4'd13, 32'hCAFEF00D, 1'b0};
      tbl[13] = '{1'b0, 3'b011, 32'h10,      32'h0,       32'h0,        4'd14, 32'h80223344, 1'b0};
      tbl[14] = '{1'b0, 3'b000, 32'h104,     32'hFFFFFFFF, 32'h0,       4'd15, 32'hFFFFFFCA, 1'b0};
      tbl[15] = '{1'b0, 3'b010, 32'h1010,    32'h0,       32'h0,        4'd0,  32'h80223344, 1'b0};
      tbl[16] = '{1'b0, 3'b111, 32'h102,     32'h0,       32'h0,        4'd3,  32'h0,        1'b1};
      tbl[17] = '{1'b0, 3'b001, 32'h11,      32'h0,       32'h0,        4'd4,  32'h0,        1'b1};
      tbl[18] = '{1'b1, 3'b001, 32'h100,     32'h2,       32'h0000BEEF, 4'd5,  32'h0,        1'b0};
      tbl[19] = '{1'b0, 3'b001, 32'h102,     32'h0,       32'h0,        4'd6,  32'hFFFFBEEF, 1'b0};
      tbl[20] = '{1'b0, 3'b010, 32'h100,     32'h0,       32'h0,        4'd7,  32'hBEEFF00D, 1'b0};

      rst = 1'b1; out_ready = 1'b1;
      drive(1'b0, 3'b0, 32'h0, 32'h0, 32'h0, 4'h0);
      in_valid = 1'b0;
      l_in_valid = 1'b0; l_in_mem_w = 1'b0; l_in_bhw = 3'b010;
      l_in_rs1 = 32'h0; l_in_imm = 32'h0; l_in_rs2 = 32'h0; l_in_tag = 4'h0; l_out_ready = 1'b1;
      tick; tick;
      chk("rst.in_ready", {31'h0, in_ready}, 32'h1);
      chk("rst.out_valid", {31'h0, out_valid}, 32'h0);
      chk("rst.out_tag", {28'h0, out_tag}, 32'h0);
      chk("rst.out_data", out_data, 32'h0);
      chk("rst.out_mis", {31'h0, out_misalign}, 32'h0);
      chk("rst.busy", {31'h0, busy}, 32'h0);
      rst = 1'b0;
      tick;

      for (int i = 0; i < NV; i++) do_op(tbl[i], $sformatf("vec%0d", i));

      // Store then load on consecutive cycles: RAW forwarding through RAM ordering
      drive(1'b1, 3'b010, 32'h20, 32'h0, 32'h55AA55AA, 4'd1);
      tick;
      drive(1'b0, 3'b010, 32'h20, 32'h0, 32'h0, 4'd2);
      tick;
      in_valid = 1'b0;
      chk("b2b.early", {31'h0, out_valid}, 32'h0);
      tick;
      chk("b2b.vld1", {31'h0, out_valid}, 32'h1);
      chk("b2b.tag1", {28'h0, out_tag}, 32'h1);
      chk("b2b.data1", out_data, 32'h0);
      tick;
      chk("b2b.vld2", {31'h0, out_valid}, 32'h1);
      chk("b2b.tag2", {28'h0, out_tag}, 32'h2);
      chk("b2b.data2", out_data, 32'h55AA55AA);
      tick;
      chk("b2b.idle", {31'h0, out_valid}, 32'h0);

      // Backpressure: credits cap acceptance at RESP_DEPTH
      out_ready = 1'b0;
      n_acc = 0;
      drive(1'b0, 3'b010, 32'h10, 32'h0, 32'h0, 4'd0);
      for (int c = 0; c < 8; c++) begin
         in_tag = n_acc[3:0];
         acc_now = in_ready;
         tick;
         if (acc_now) n_acc++;
      end
      in_valid = 1'b0;
      chk("bp.accepts", n_acc, 4);
      chk("bp.ready_full", {31'h0, in_ready}, 32'h0);
      chk("bp.busy", {31'h0, busy}, 32'h1);
      out_ready = 1'b1;
      chk("bp.tag0", {28'h0, out_tag}, 32'h0);
      chk("bp.data0", out_data, 32'h80223344);
      tick;
      chk("bp.ready_after", {31'h0, in_ready}, 32'h1);
      for (int k = 1; k < 4; k++) begin
         chk($sformatf("bp.vld%0d", k), {31'h0, out_valid}, 32'h1);
         chk($sformatf("bp.tag%0d", k), {28'h0, out_tag}, k);
         tick;
      end
      chk("bp.drained", {31'h0, out_valid}, 32'h0);
      chk("bp.idle", {31'h0, busy}, 32'h0);

      // Reset with three ops in flight; the trailing store must never land
      do_op('{1'b1, 3'b010, 32'h40, 32'h0, 32'h0BADF00D, 4'd1, 32'h0, 1'b0}, "rst.pre");
      drive(1'b0, 3'b010, 32'h10, 32'h0, 32'h0, 4'd1);
      tick;
      in_tag = 4'd2;
      tick;
      drive(1'b1, 3'b010, 32'h40, 32'h0, 32'h12345678, 4'd3);
      tick;
      in_valid = 1'b0;
      chk("rst.busy_before", {31'h0, busy}, 32'h1);
      rst = 1'b1;
      tick;
      chk("rst.mid_vld", {31'h0, out_valid}, 32'h0);
      chk("rst.mid_busy", {31'h0, busy}, 32'h0);
      chk("rst.mid_ready", {31'h0, in_ready}, 32'h1);
      rst = 1'b0;
      tick;
      do_op('{1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 4'd4, 32'h0BADF00D, 1'b0}, "rst.post");

      // EXTRA_LAT=3 instance
      l_in_valid = 1'b1; l_in_mem_w = 1'b1; l_in_rs2 = 32'h13572468; l_in_tag = 4'd9;
      tick;
      l_in_valid = 1'b0; l_in_mem_w = 1'b0;
      lat = 0;
      while (!l_out_valid && lat < 20) begin tick; lat++; end
      if (!l_out_valid) timeout("l3.store");
      else chk("l3.store_tag", {28'h0, l_out_tag}, 32'h9);
      tick;
      l_in_valid = 1'b1; l_in_tag = 4'd10;
      tick;
      l_in_valid = 1'b0;
      lat = 0;
      while (!l_out_valid && lat < 20) begin tick; lat++; end
      if (!l_out_valid) timeout("l3.load");
      else begin
         chk("l3.lat", lat, 5);
         chk("l3.data", l_out_data, 32'h13572468);
         chk("l3.mis", {31'h0, l_out_misalign}, 32'h0);
      end
      tick;
      for (int k = 1; k <= 4; k++) begin
         l_in_valid = 1'b1; l_in_tag = 4'(k);
         tick;
      end
      l_in_valid = 1'b0;
      lat = 0;
      while (!l_out_valid && lat < 20) begin tick; lat++; end
      if (!l_out_valid) timeout("l3.stream");
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("l3.s_vld%0d", k), {31'h0, l_out_valid}, 32'h1);
         chk($sformatf("l3.s_tag%0d", k), {28'h0, l_out_tag}, k);
         tick;
      end
      chk("l3.idle", {31'h0, l_busy}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
